// File: rtl/fcl_controller_if.sv
`default_nettype none
// ============================================================================
// Module : defs (package) / fcl_controller_if (interface)
// Brief  : Load-request type and the command/handshake bundle of the FCL
//          controller.
// Rev    : 1.0 - initial release
// ============================================================================

package defs;
  typedef enum logic [1:0] {
    NO_REQ = 2'd0,
    CFG_1  = 2'd1,
    CFG_2  = 2'd2
  } load_cfg_req_t;
endpackage

interface fcl_controller_if;
  import defs::*;

  logic          i_cmd_load_cfg_1;
  logic          i_cmd_load_cfg_2;
  logic          i_FCL_allowed;
  logic          i_is_loading;
  logic          o_go;
  load_cfg_req_t o_cur_load_cfg_req;

  modport master (
    output i_cmd_load_cfg_1,
    output i_cmd_load_cfg_2,
    output i_FCL_allowed,
    output i_is_loading,
    input  o_go,
    input  o_cur_load_cfg_req
  );

  modport slave (
    input  i_cmd_load_cfg_1,
    input  i_cmd_load_cfg_2,
    input  i_FCL_allowed,
    input  i_is_loading,
    output o_go,
    output o_cur_load_cfg_req
  );
endinterface

`default_nettype wire

// File: rtl/fcl_controller.sv
`default_nettype none
// ============================================================================
// Module : fcl_controller
// Brief  : Arbitrates the two load-configuration commands into one request,
//          waits for the core to allow loading, strobes o_go and holds the
//          request until the loader finishes.
//          Optional macro FCL_CTRL_START_TIMEOUT_EN aborts WAIT_START after
//          START_TIMEOUT cycles without i_is_loading.
// Rev    : 1.0 - initial release
// ============================================================================

module fcl_controller
  import defs::*;
#(
  parameter int unsigned START_TIMEOUT = 16
) (
  input  wire              clk,
  input  wire              rst,
  fcl_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_ALLOWED = 2'd1,
    WAIT_START   = 2'd2,
    LOADING      = 2'd3
  } state_t;

  state_t        r_state;
  load_cfg_req_t r_req;
  logic          r_cmd1_q;
  logic          r_cmd2_q;
  logic          w_rise1;
  logic          w_rise2;
  logic [31:0]   w_unused_timeout;

  assign w_rise1 = bus.i_cmd_load_cfg_1 & ~r_cmd1_q;
  assign w_rise2 = bus.i_cmd_load_cfg_2 & ~r_cmd2_q;
  assign w_unused_timeout = START_TIMEOUT;

  // Mealy strobe: follows i_FCL_allowed without waiting for a clock.
  assign bus.o_go               = (r_state == WAIT_ALLOWED) & bus.i_FCL_allowed;
  assign bus.o_cur_load_cfg_req = r_req;

`ifdef FCL_CTRL_START_TIMEOUT_EN
  localparam int unsigned C_CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(START_TIMEOUT - 1);

  logic [C_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd1_q <= 1'b0;
      r_cmd2_q <= 1'b0;
      r_state  <= IDLE;
      r_req    <= NO_REQ;
      r_cnt    <= '0;
    end else begin
      r_cmd1_q <= bus.i_cmd_load_cfg_1;
      r_cmd2_q <= bus.i_cmd_load_cfg_2;
      case (r_state)
        IDLE: begin
          r_req <= NO_REQ;
          if (w_rise1) begin
            r_req   <= CFG_1;
            r_state <= WAIT_ALLOWED;
          end else if (w_rise2) begin
            r_req   <= CFG_2;
            r_state <= WAIT_ALLOWED;
          end
        end
        WAIT_ALLOWED: begin
          if (bus.i_FCL_allowed) begin
            r_state <= WAIT_START;
            r_cnt   <= '0;
          end
        end
        WAIT_START: begin
          if (bus.i_is_loading) begin
            r_state <= LOADING;
          end else if (r_cnt == C_CNT_LAST) begin
            r_state <= IDLE;
            r_req   <= NO_REQ;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LOADING: begin
          if (!bus.i_is_loading) begin
            r_state <= IDLE;
            r_req   <= NO_REQ;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= NO_REQ;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd1_q <= 1'b0;
      r_cmd2_q <= 1'b0;
      r_state  <= IDLE;
      r_req    <= NO_REQ;
    end else begin
      r_cmd1_q <= bus.i_cmd_load_cfg_1;
      r_cmd2_q <= bus.i_cmd_load_cfg_2;
      case (r_state)
        IDLE: begin
          r_req <= NO_REQ;
          if (w_rise1) begin
            r_req   <= CFG_1;
            r_state <= WAIT_ALLOWED;
          end else if (w_rise2) begin
            r_req   <= CFG_2;
            r_state <= WAIT_ALLOWED;
          end
        end
        WAIT_ALLOWED: begin
          if (bus.i_FCL_allowed) r_state <= WAIT_START;
        end
        WAIT_START: begin
          if (bus.i_is_loading) r_state <= LOADING;
        end
        LOADING: begin
          if (!bus.i_is_loading) begin
            r_state <= IDLE;
            r_req   <= NO_REQ;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= NO_REQ;
        end
      endcase
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fcl_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_fcl_controller
// Brief  : Directed self-checking bench for fcl_controller.
// Rev    : 1.0 - initial release
// ============================================================================

module tb_fcl_controller;
  import defs::*;

  localparam int unsigned C_TIMEOUT = 16;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   go_cnt   = 0;
  int   go_base;

  fcl_controller_if bus ();

  fcl_controller #(.START_TIMEOUT(C_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are stable from posedge+1 onwards, so o_go at negedge equals o_go
  // at the following accepting edge.
  always @(negedge clk) if (bus.o_go) go_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] req_v(input load_cfg_req_t r);
    return 32'(r);
  endfunction

  initial begin
    rst = 1'b1;
    bus.i_cmd_load_cfg_1 = 1'b0;
    bus.i_cmd_load_cfg_2 = 1'b0;
    bus.i_FCL_allowed    = 1'b0;
    bus.i_is_loading     = 1'b0;
    tick(2);
    check("rst_req", req_v(bus.o_cur_load_cfg_req), req_v(NO_REQ));
    check("rst_go", 32'(bus.o_go), 0);
    rst = 1'b0;
    tick();
    check("post_rst_req", req_v(bus.o_cur_load_cfg_req), req_v(NO_REQ));

    // Full cycle
    go_base = go_cnt;
    bus.i_cmd_load_cfg_1 = 1'b1;
    tick(3);
    check("wait_req", req_v(bus.o_cur_load_cfg_req), req_v(CFG_1));
    check("wait_go", 32'(bus.o_go), 0);
    #2;
    bus.i_FCL_allowed = 1'b1;
    #1;
    check("go_comb", 32'(bus.o_go), 1);
    check("go_req", req_v(bus.o_cur_load_cfg_req), req_v(CFG_1));
    bus.i_is_loading = 1'b1;
    tick();
    bus.i_FCL_allowed = 1'b0;
    tick();
    check("load_go", 32'(bus.o_go), 0);
    check("load_req", req_v(bus.o_cur_load_cfg_req), req_v(CFG_1));
    bus.i_cmd_load_cfg_1 = 1'b0;
    tick();
    check("cmd_drop_req", req_v(bus.o_cur_load_cfg_req), req_v(CFG_1));
    bus.i_is_loading = 1'b0;
    tick();
    check("done_req", req_v(bus.o_cur_load_cfg_req), req_v(NO_REQ));
    check("full_go_pulses", 32'(go_cnt - go_base), 1);

    // Priority: both commands rise together
    bus.i_cmd_load_cfg_1 = 1'b1;
    bus.i_cmd_load_cfg_2 = 1'b1;
    tick();
    check("prio_req", req_v(bus.o_cur_load_cfg_req), req_v(CFG_1));
    bus.i_FCL_allowed = 1'b1;
    tick();
    bus.i_FCL_allowed = 1'b0;
    bus.i_is_loading  = 1'b1;
    tick();
    bus.i_is_loading  = 1'b0;
    tick();
    bus.i_cmd_load_cfg_1 = 1'b0;
    bus.i_cmd_load_cfg_2 = 1'b0;
    tick();
    check("prio_done", req_v(bus.o_cur_load_cfg_req), req_v(NO_REQ));

    // cmd_2 alone, held through the whole load plus 10 idle cycles
    go_base = go_cnt;
    bus.i_cmd_load_cfg_2 = 1'b1;
    tick();
    check("cfg2_req", req_v(bus.o_cur_load_cfg_req), req_v(CFG_2));
    bus.i_FCL_allowed = 1'b1;
    tick();
    bus.i_FCL_allowed = 1'b0;
    bus.i_is_loading  = 1'b1;
    tick(2);
    check("cfg2_load_req", req_v(bus.o_cur_load_cfg_req), req_v(CFG_2));
    bus.i_is_loading = 1'b0;
    tick();
    bus.i_FCL_allowed = 1'b1;
    tick(10);
    check("noretrig_req", req_v(bus.o_cur_load_cfg_req), req_v(NO_REQ));
    check("noretrig_go", 32'(bus.o_go), 0);
    check("noretrig_pulses", 32'(go_cnt - go_base), 1);
    bus.i_FCL_allowed    = 1'b0;
    bus.i_cmd_load_cfg_2 = 1'b0;
    tick();

    // cmd_2 pulse while loading CFG_1 is dropped
    go_base = go_cnt;
    bus.i_cmd_load_cfg_1 = 1'b1;
    tick();
    bus.i_cmd_load_cfg_1 = 1'b0;
    bus.i_FCL_allowed    = 1'b1;
    tick();
    bus.i_FCL_allowed = 1'b0;
    bus.i_is_loading  = 1'b1;
    tick(2);
    bus.i_cmd_load_cfg_2 = 1'b1;
    tick();
    bus.i_cmd_load_cfg_2 = 1'b0;
    tick();
    check("ign_req", req_v(bus.o_cur_load_cfg_req), req_v(CFG_1));
    bus.i_is_loading = 1'b0;
    tick();
    check("ign_done", req_v(bus.o_cur_load_cfg_req), req_v(NO_REQ));
    bus.i_FCL_allowed = 1'b1;
    tick(3);
    check("ign_idle_req", req_v(bus.o_cur_load_cfg_req), req_v(NO_REQ));
    check("ign_idle_go", 32'(bus.o_go), 0);
    check("ign_pulses", 32'(go_cnt - go_base), 1);
    bus.i_FCL_allowed = 1'b0;
    tick();

    // i_is_loading already high at the go edge: one WAIT_START cycle first
    bus.i_cmd_load_cfg_1 = 1'b1;
    tick();
    bus.i_cmd_load_cfg_1 = 1'b0;
    bus.i_FCL_allowed    = 1'b1;
    bus.i_is_loading     = 1'b1;
    tick();
    bus.i_FCL_allowed = 1'b0;
    bus.i_is_loading  = 1'b0;
    tick();
    check("ws_hold_req", req_v(bus.o_cur_load_cfg_req), req_v(CFG_1));
    bus.i_is_loading = 1'b1;
    tick();
    bus.i_is_loading = 1'b0;
    tick();
    check("ws_done_req", req_v(bus.o_cur_load_cfg_req), req_v(NO_REQ));

    // Asynchronous reset during LOADING, command held across release
    bus.i_cmd_load_cfg_1 = 1'b1;
    tick();
    bus.i_FCL_allowed = 1'b1;
    tick();
    bus.i_FCL_allowed = 1'b0;
    bus.i_is_loading  = 1'b1;
    tick(2);
    check("pre_rst_req", req_v(bus.o_cur_load_cfg_req), req_v(CFG_1));
    rst = 1'b1;
    #1;
    check("async_rst_req", req_v(bus.o_cur_load_cfg_req), req_v(NO_REQ));
    check("async_rst_go", 32'(bus.o_go), 0);
    bus.i_is_loading = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("held_cmd_req", req_v(bus.o_cur_load_cfg_req), req_v(CFG_1));
    bus.i_cmd_load_cfg_1 = 1'b0;

    // WAIT_START with allowed but no loader response
    bus.i_FCL_allowed = 1'b1;
    tick();
    bus.i_FCL_allowed = 1'b0;
`ifdef FCL_CTRL_START_TIMEOUT_EN
    tick(C_TIMEOUT - 1);
    check("to_before_req", req_v(bus.o_cur_load_cfg_req), req_v(CFG_1));
    tick();
    check("to_abort_req", req_v(bus.o_cur_load_cfg_req), req_v(NO_REQ));
`else
    tick(C_TIMEOUT + 4);
    check("no_to_req", req_v(bus.o_cur_load_cfg_req), req_v(CFG_1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
